// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
//   SEG_OFF / AN_OFF : all segments / all anodes inactive (active-low pins)
//   HEX7_TABLE       : active-high gfedcba patterns for hex digits 0..F
//                      (uppercase A, C, E, F; lowercase b, d)
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Segment pattern with all of a..g dark, active-low.
  localparam logic [6:0] SEG7_DARK = 7'h7F;

  localparam logic [6:0] HEX7_TABLE [0:15] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-nibble to seven-segment decoder, active-low outputs.
//   nib   : 4-bit hex value
//   seg_n : {g,f,e,d,c,b,a}, 0 = segment lit
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = ~HEX7_TABLE[nib];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver.
// Follows the free-running digit position from the clock divider, latches a
// 32-bit hex word plus decimal-point mask on a write strobe, and commits it to
// the display only when the scan wraps 7->0 so a frame never mixes old and new
// digits. Every digit switch is followed by a dead-time blank to suppress
// ghosting on the board.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   pos      3-bit scan position from the divider (normally +1 mod 8)
//   data_in  hex word, digit k = data_in[4k+3:4k]
//   dp_in    decimal-point enable per digit
//   data_we  one-cycle write strobe for data_in/dp_in
//   pending  a written value is waiting for the next frame commit
//   an       anode select, active-low, one-hot-cold
//   seg      {dp,g,f,e,d,c,b,a}, active-low
//
// Build option: define LEADING_ZERO_BLANK_EN to darken leading zero digits
// (digit 0 is always shown; decimal points are unaffected).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pos,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        data_we,
  output logic        pending,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam logic [CNT_W-1:0] BlankMax = CNT_W'(BLANK_CYCLES);

  logic [2:0]       pos_q;
  logic [CNT_W-1:0] dead_cnt;
  logic [31:0]      shadow_data;
  logic [7:0]       shadow_dp;
  logic [31:0]      disp_data;
  logic [7:0]       disp_dp;

  logic             pos_chg;
  logic             commit;
  logic             blanking;
  logic [3:0]       cur_nib;
  logic [6:0]       cur_seg_n;
  logic             digit_dark;

  // ---------------------------------------------------------------------------
  // Scan position tracking and frame commit
  // ---------------------------------------------------------------------------
  always_comb begin
    pos_chg = (pos != pos_q);
    // Commit only on the wrap into digit 0 so a whole frame shows one value.
    commit  = pos_chg && (pos == 3'd0) && pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= 3'd0;
    end else begin
      pos_q <= pos;
    end
  end

  // A write in the commit cycle lands in the shadow after the commit has taken
  // the old shadow contents, so pending stays set for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data <= 32'h0;
      shadow_dp   <= 8'h00;
      pending     <= 1'b0;
    end else begin
      if (data_we) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      if (data_we) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data <= 32'h0;
      disp_dp   <= 8'h00;
    end else if (commit) begin
      disp_data <= shadow_data;
      disp_dp   <= shadow_dp;
    end
  end

  // ---------------------------------------------------------------------------
  // Dead-time counter: restarts on every position change, saturates at the
  // blank length. Reset value is the saturated value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dead_cnt <= BlankMax;
    end else if (pos_chg) begin
      dead_cnt <= '0;
    end else if (dead_cnt < BlankMax) begin
      dead_cnt <= dead_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nib = disp_data[{pos_q, 2'b00} +: 4];
  end

  seg_hex_decode u_hex_decode (
    .nib   (cur_nib),
    .seg_n (cur_seg_n)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] lead_zero;

  // Digit k is a leading zero when it and every digit above it are zero.
  // Digit 0 is never darkened so a zero value still shows a single "0".
  always_comb begin
    lead_zero = 8'h00;
    for (int k = 1; k < 8; k++) begin
      lead_zero[k] = ~|(disp_data >> (4 * k));
    end
  end

  always_comb begin
    digit_dark = lead_zero[pos_q];
  end
`else
  always_comb begin
    digit_dark = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered output stage
  // ---------------------------------------------------------------------------
  always_comb begin
    blanking = pos_chg || (dead_cnt < BlankMax);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else if (blanking) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(8'b1 << pos_q);
      seg <= {~disp_dp[pos_q], (digit_dark ? SEG7_DARK : cur_seg_n)};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver. Each stimulus cycle runs a
// frame-level reference model and queues the expected pin state after the next
// clock edge; an independent monitor pops and compares after each edge.
module tb_seg_scan_driver;

  localparam int BLANK = 16;

  // Active-high gfedcba segment patterns for hex digits.
  localparam logic [6:0] HEX_ON [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst;
  logic [2:0]  pos;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        data_we;
  logic        pending;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Scoreboard entries: {an, seg, pending}
  logic [16:0] sb [$];

  // Reference model state
  logic [2:0]  m_pos;       // last position seen at a clock edge
  int          m_stable;    // edges since the position last changed
  logic [31:0] m_disp;
  logic [7:0]  m_dpm;
  logic [31:0] m_shadow;
  logic [7:0]  m_sdp;
  logic        m_pend;

  seg_scan_driver #(
    .BLANK_CYCLES (BLANK),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pos     (pos),
    .data_in (data_in),
    .dp_in   (dp_in),
    .data_we (data_we),
    .pending (pending),
    .an      (an),
    .seg     (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] digit_seg(input logic [31:0] d, input logic [7:0] m, input int k);
    logic [31:0] upper;
    logic [3:0]  nib;
    logic [6:0]  pat;
    upper = d >> (4 * k);
    nib   = upper[3:0];
    pat   = HEX_ON[nib];
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && upper == 32'h0) pat = 7'h00;
`endif
    return ~{m[k], pat};
  endfunction

  task automatic model_reset();
    m_pos    = 3'd0;
    m_stable = BLANK;
    m_disp   = 32'h0;
    m_dpm    = 8'h00;
    m_shadow = 32'h0;
    m_sdp    = 8'h00;
    m_pend   = 1'b0;
  endtask

  // Call at a falling edge: drives one cycle of inputs, predicts the outputs
  // after the coming rising edge, and returns at the next falling edge.
  task automatic cyc(input logic [2:0] p, input logic we, input logic [31:0] d,
                     input logic [7:0] m);
    logic [7:0] e_an;
    logic [7:0] e_seg;
    logic       moved;
    pos     = p;
    data_we = we;
    data_in = d;
    dp_in   = m;
    moved   = (p != m_pos);
    if (moved) m_stable = 0;
    else if (m_stable <= BLANK) m_stable++;
    // A digit is lit once it has been steady for more than the blank length.
    if (m_stable > BLANK) begin
      e_an  = ~(8'b1 << p);
      e_seg = digit_seg(m_disp, m_dpm, int'(p));
    end else begin
      e_an  = 8'hFF;
      e_seg = 8'hFF;
    end
    if (moved && p == 3'd0 && m_pend) begin
      m_disp = m_shadow;
      m_dpm  = m_sdp;
      m_pend = 1'b0;
    end
    if (we) begin
      m_shadow = d;
      m_sdp    = m;
      m_pend   = 1'b1;
    end
    m_pos = p;
    sb.push_back({e_an, e_seg, m_pend});
    @(negedge clk);
  endtask

  task automatic hold(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) cyc(p, 1'b0, $urandom, 8'($urandom));
  endtask

  task automatic frame(input int n);
    for (int p = 0; p < 8; p++) hold(3'(p), n);
  endtask

  task automatic check_reset_pins(input string tag);
    checks++;
    if (an !== 8'hFF || seg !== 8'hFF || pending !== 1'b0) begin
      errors++;
      $display("FAIL %s: an=%h seg=%h pending=%b, required an=ff seg=ff pending=0",
               tag, an, seg, pending);
    end
  endtask

  // Monitor
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    cycle++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({an, seg, pending} !== e) begin
        errors++;
        $display("FAIL scan cycle=%0d pos=%0d: an=%h seg=%h pending=%b, required an=%h seg=%h pending=%b",
                 cycle, pos, an, seg, pending, e[16:9], e[8:1], e[0]);
      end
    end
  end

  initial begin
    logic [2:0]  p;
    logic [31:0] d;
    int          n;
    rst     = 1'b1;
    pos     = 3'd0;
    data_in = 32'h0;
    dp_in   = 8'h00;
    data_we = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_pins("reset_state");
    rst = 1'b0;

    // Plain scan with nothing written: every digit shows "0".
    frame(20);
    hold(3'd0, 20);

    // Single write mid-frame, visible only after the wrap.
    hold(3'd1, 20);
    hold(3'd2, 20);
    cyc(3'd3, 1'b1, 32'h1234ABCD, 8'h00);
    hold(3'd3, 19);
    for (int q = 4; q < 8; q++) hold(3'(q), 20);
    frame(20);

    // Two writes before a wrap: only the last one is ever shown.
    hold(3'd1, 20);
    cyc(3'd2, 1'b1, 32'h11111111, 8'h00);
    hold(3'd2, 10);
    cyc(3'd2, 1'b1, 32'h22222222, 8'h00);
    for (int q = 3; q < 8; q++) hold(3'(q), 20);
    frame(20);

    // Write coinciding with the commit edge; dp mask 81 goes out first.
    hold(3'd1, 20);
    cyc(3'd6, 1'b1, 32'hAAAA5555, 8'h81);
    hold(3'd6, 19);
    hold(3'd7, 20);
    cyc(3'd0, 1'b1, 32'h00000A05, 8'h00);
    hold(3'd0, 19);
    for (int q = 1; q < 8; q++) hold(3'(q), 20);
    frame(20);

    // Asynchronous reset in the middle of a lit digit.
    hold(3'd1, 22);
    #2 rst = 1'b1;
    #1 check_reset_pins("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    frame(20);

    // Randomized scan: mostly +1 steps, occasional skips and short holds.
    p = 3'd0;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) == 0) p = 3'($urandom);
      else p = p + 3'd1;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 17)) : int'($urandom_range(17, 26));
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 0) d = d >> (4 * $urandom_range(1, 8));
        cyc(p, ($urandom_range(0, 39) == 0), d, 8'($urandom));
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
